// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: accepts one aligned, byte-masked read or write per handshake
// and returns a single-cycle response LATENCY edges later. o_dbg_state: 0=IDLE, 1=WAIT, 2=RESP.
module dmem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_addr,
   input  logic        i_req_ren,
   input  logic        i_req_wen,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_mask,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic [1:0]  o_dbg_state
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [32:0]   SPAN     = 33'(4 * DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, wdata_q;
   logic          ren_q, wen_q;
   logic [3:0]    mask_q;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   mem_q [DEPTH];

   logic          accept;
   logic          access;
   logic [32:0]   offset;
   logic          req_err;
   logic [AW-1:0] word_idx;
   logic [31:0]   lane_mask;

   // Handshake: a request transfers on an edge where i_req_valid and o_req_ready are both high;
   // the response has no backpressure and is valid for exactly one cycle.
   assign accept   = i_req_valid && (state_q == ST_IDLE);
   assign access   = (state_q == ST_WAIT) && (cnt_q == '0);

   // 33-bit offset: bit 32 is the borrow, set when the address lies below BASE_ADDR.
   assign offset   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
   assign req_err  = (addr_q[1:0] != 2'b00) || offset[32] || (offset >= SPAN) ||
                     (ren_q == wen_q) || (mask_q == 4'b0000);
   assign word_idx = offset[AW+1:2];
   assign lane_mask = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = ST_RESP;
               err_d   = req_err;
               rdata_d = (!req_err && ren_q) ? (mem_q[word_idx] & lane_mask) : 32'h0;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         mask_q  <= 4'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            ren_q   <= i_req_ren;
            wen_q   <= i_req_wen;
            mask_q  <= i_req_mask;
         end
      end
   end

   // Storage is not reset; reset forces IDLE, so a write pending in WAIT never reaches here.
   always_ff @(posedge i_clk) begin
      if (access && !req_err && wen_q) begin
         for (int b = 0; b < 4; b++) begin
            if (mask_q[b]) begin
               mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   assign o_req_ready  = (state_q == ST_IDLE);
   assign o_resp_valid = (state_q == ST_RESP);
   assign o_resp_rdata = rdata_q;
   assign o_resp_err   = err_q;
   assign o_dbg_state  = state_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data memory responder: the memory end of the hart's dmem port, built as the multi-cycle memory that replaces the combinational model in the later pipelined phases. It accepts one word-aligned read or byte-masked write per valid/ready handshake, performs it after a fixed latency, and returns a one-cycle response carrying read data or an error flag. Storage is an internal word array; only one request is outstanding at a time.

## Interface
- DEPTH, 1024, storage size in 32-bit words (power of two, ≥ 4)
- LATENCY, 2, edges from request accept to response (≥ 1)
- BASE_ADDR, 32'h00000000, byte address of word 0 (word aligned)

- i_clk  in  1  global clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  responder can accept a request this cycle
- i_req_addr  in  32  byte address; must be word aligned
- i_req_ren  in  1  read request
- i_req_wen  in  1  write request
- i_req_wdata  in  32  write data, already shifted into byte lanes
- i_req_mask  in  4  byte-lane enables
- o_resp_valid  out  1  response valid, exactly one cycle per accepted request
- o_resp_rdata  out  32  read data; masked-off lanes are zero
- o_resp_err  out  1  request was illegal; no side effect

## Operation
- Reset is asynchronous and active-low. While i_rst_n is low: state IDLE, counter 0, o_resp_valid 0, o_resp_rdata 0, o_resp_err 0. o_req_ready reads 1 in IDLE after reset deassertion. Storage contents are not cleared by reset and are undefined at power-up.
- States:
  - IDLE: o_req_ready = 1. The request is accepted on an edge where i_req_valid & o_req_ready. The accept captures addr, ren, wen, wdata and mask into registers, loads cnt = LATENCY-1, and moves to WAIT.
  - WAIT: o_req_ready = 0. When cnt != 0, decrement. When cnt == 0, the next edge performs the access and moves to RESP.
  - RESP: o_resp_valid = 1, o_req_ready = 0. The next edge returns to IDLE. There is no response backpressure.
- Legality check on the captured request. The request is an error if any of the following holds; err is evaluated at the access edge:
  - addr[1:0] != 0
  - addr < BASE_ADDR or addr ≥ BASE_ADDR + 4*DEPTH
  - ren == wen (both set or neither set)
  - mask == 0
- Word index = (addr - BASE_ADDR) >> 2, using the low log2(DEPTH) bits.
- Legal write: lane b of the word is replaced by wdata[8b+7:8b] where mask[b] is set. Other lanes are unchanged. o_resp_rdata = 0.
- Legal read: o_resp_rdata lane b = stored lane b where mask[b] is set, and 0 otherwise. Read data is the stored value after all previously responded writes.
- Error: no storage change, o_resp_rdata = 0, o_resp_err = 1.
- o_resp_rdata and o_resp_err are registered at the access edge. They hold their value until the next access edge and are meaningful only while o_resp_valid is high.
- Request inputs are ignored outside the accept edge. Changes after the accept edge have no effect.

## Timing
- The accept happens at edge e0. o_resp_valid is high for the cycle after edge e0+LATENCY.
- o_req_ready rises after edge e0+LATENCY+1.
- Throughput is one request per LATENCY+2 cycles.
- LATENCY = 1: the design passes through WAIT for one cycle with cnt = 0, then enters RESP.
- Reset asserted in WAIT: the pending request is dropped and no write occurs.
- Reset asserted in RESP: o_resp_valid drops immediately.
- Reset asserted on the same cycle as i_req_valid: the request is not accepted.
- A write completes at its access edge. A read accepted immediately afterwards observes the written data.

## Test plan
- Reset, then write addr 0x10, mask 4'b1111, wdata 0xDEADBEEF; read 0x10 with mask 1111 -> write response err=0 rdata=0; read response rdata=0xDEADBEEF exactly 2 edges after accept, valid for 1 cycle.
- Write 0x12345678 at 0x20, then write mask 4'b0100 with wdata 0x00AB0000, then read mask 1111 -> 0x12AB5678. Read mask 1100 -> 0x12AB0000.
- Errors → err=1, rdata=0, memory unchanged on re-read:
  - addr 0x22 (unaligned)
  - addr BASE_ADDR+4*DEPTH (out of range)
  - ren=wen=1
  - mask 0
- Back-to-back requests with i_req_valid held high:
  - ready pattern repeats 1,0,0,0 for LATENCY=2.
  - each request is accepted once.
  - inputs changed after accept do not alter the response.
- Drop i_rst_n during WAIT of a write of 0xFFFFFFFF to 0x30 that was preceded by a write of 0 → after reset, the read of 0x30 returns 0, and o_resp_valid is 0 during reset.
- LATENCY=1 build → response valid the cycle after accept+1 edge; LATENCY=4 build → response valid 4 edges after accept.
